// File: rtl/fetch_pc_unit.sv
// Program-counter and fetch-control stage in front of the instruction memory.
// Owns the PC, presents the fetch address combinationally, registers the
// returned instruction behind a valid/ready output, applies branch/jump
// redirects, detects fetch faults, halts, and counts delivered instructions.
module fetch_pc_unit #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         INSTR_WIDTH   = 32,
  parameter int                         LENGTH        = 64,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] Adress,
  input  logic [INSTR_WIDTH-1:0]   instruction,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  input  logic                     halt_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [ADDRESS_WIDTH-1:0] out_pc_plus4,
  output logic                     halted,
  output logic [1:0]               fault,
  output logic [31:0]              fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(4 * LENGTH - 4);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP = ADDRESS_WIDTH'(4);

  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
  localparam logic [1:0] FAULT_RANGE     = 2'b10;

  state_t                     state;
  state_t                     state_nxt;
  logic [ADDRESS_WIDTH-1:0]   pc;
  logic [ADDRESS_WIDTH-1:0]   pc_nxt;
  logic [ADDRESS_WIDTH-1:0]   pc_plus4;
  logic [1:0]                 fault_nxt;
  logic                       load;
  logic                       clr_valid;
  logic                       handshake;
  logic                       pc_bad;

  assign Adress    = pc;
  assign halted    = (state == HALT);
  assign pc_plus4  = pc + WORD_STEP;
  assign handshake = out_valid & out_ready;
  assign pc_bad    = (pc > LAST_ADDR) || (pc[1:0] != 2'b00);

  // State, PC and fault register updates; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_VECTOR;
      fault <= FAULT_NONE;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      fault <= fault_nxt;
    end
  end

  // Prioritised RUN-state decisions: halt, bad redirect, redirect, bad PC, load, stall.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_nxt = fault;
    load      = 1'b0;
    clr_valid = 1'b0;
    if (state == RUN) begin
      if (halt_req) begin
        state_nxt = HALT;
        clr_valid = 1'b1;
      end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
        fault_nxt = FAULT_MISALIGN;
        state_nxt = HALT;
        clr_valid = 1'b1;
      end else if (redirect_valid) begin
        // The instruction fetched this cycle belongs to the wrong path.
        pc_nxt    = redirect_target;
        clr_valid = 1'b1;
      end else if (pc_bad) begin
        fault_nxt = FAULT_RANGE;
        state_nxt = HALT;
        clr_valid = 1'b1;
      end else if (!out_valid || out_ready) begin
        load   = 1'b1;
        pc_nxt = pc_plus4;
      end
    end
  end

  // Output register: captures the fetched word, holds it stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_pc_plus4 <= '0;
    end else if (clr_valid) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_instr    <= instruction;
      out_pc       <= pc;
      out_pc_plus4 <= pc_plus4;
    end
  end

  // Delivered-instruction counter; a handshake in a redirect or halt cycle still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (handshake) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
